ub_affine_loop_controller: RTL and testbench



---
 rtl/ub_affine_loop_controller.sv | 107 ++++++++++
 tb/tb_ub_affine_loop_controller.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/ub_affine_loop_controller.sv
// Drives one unified-buffer port through a 3-level affine loop nest.
// It issues one enable pulse plus the loop indices every II cycles, after a start delay.
module ub_affine_loop_controller #(
  parameter int unsigned EXTENT_0    = 1,
  parameter int unsigned EXTENT_2    = 64,
  parameter int unsigned EXTENT_1    = 64,
  parameter int unsigned II          = 1,
  parameter int unsigned START_DELAY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              start,
  input  logic              stall,
  output logic              op_en,
  output logic [2:0][15:0]  ctrl_vars,
  output logic              busy,
  output logic              done
);

  // state | meaning
  // IDLE  | waiting for start
  // DELAY | counting down the start delay
  // RUN   | issuing one point every II cycles
  // DONE  | pass complete, indices hold the final point
  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_RUN, S_DONE} state_t;

  localparam logic [15:0] LAST_0 = 16'(EXTENT_0 - 1);
  localparam logic [15:0] LAST_1 = 16'(EXTENT_1 - 1);
  localparam logic [15:0] LAST_2 = 16'(EXTENT_2 - 1);
  localparam logic [15:0] II_M1  = 16'(II - 1);
  localparam logic [15:0] DLY_M1 = 16'(START_DELAY - 1);

  state_t             state_q;
  logic [15:0]        dcnt_q;
  logic [15:0]        iicnt_q;
  logic [2:0][15:0]   idx_q;

  logic wrap_1, wrap_2, last_pt;

  assign wrap_1  = (idx_q[1] == LAST_1);
  assign wrap_2  = (idx_q[2] == LAST_2);
  assign last_pt = wrap_1 && wrap_2 && (idx_q[0] == LAST_0);

  assign op_en     = (state_q == S_RUN) && (iicnt_q == 16'd0) && !stall;
  assign ctrl_vars = idx_q;
  assign busy      = (state_q == S_DELAY) || (state_q == S_RUN);
  assign done      = (state_q == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      iicnt_q <= '0;
      idx_q   <= '0;
    end else if (flush) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      iicnt_q <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx_q   <= '0;
            iicnt_q <= '0;
            if (START_DELAY == 0) begin
              state_q <= S_RUN;
            end else begin
              state_q <= S_DELAY;
              dcnt_q  <= DLY_M1;
            end
          end
        end
        S_DELAY: begin
          if (!stall) begin
            if (dcnt_q != 16'd0) dcnt_q <= dcnt_q - 16'd1;
            else                 state_q <= S_RUN;
          end
        end
        S_RUN: begin
          if (op_en) begin
            iicnt_q <= II_M1;
            // the final point is held on the outputs rather than wrapping to zero
            if (last_pt) begin
              state_q <= S_DONE;
            end else if (!wrap_1) begin
              idx_q[1] <= idx_q[1] + 16'd1;
            end else begin
              idx_q[1] <= '0;
              if (!wrap_2) begin
                idx_q[2] <= idx_q[2] + 16'd1;
              end else begin
                idx_q[2] <= '0;
                idx_q[0] <= idx_q[0] + 16'd1;
              end
            end
          end else if (!stall && iicnt_q != 16'd0) begin
            iicnt_q <= iicnt_q - 16'd1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ub_affine_loop_controller.sv
// Random start/stall/flush/reset stimulus on two controller configurations.
// A point-count / elapsed-cycle reference model predicts every output each cycle.
module tb_ub_affine_loop_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;

  logic             op_en_a, busy_a, done_a;
  logic [2:0][15:0] cv_a;
  logic             op_en_b, busy_b, done_b;
  logic [2:0][15:0] cv_b;

  always #5 clk = ~clk;

  ub_affine_loop_controller #(
    .EXTENT_0(2), .EXTENT_2(3), .EXTENT_1(4), .II(2), .START_DELAY(3)
  ) u_dut_a (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .stall(stall),
    .op_en(op_en_a), .ctrl_vars(cv_a), .busy(busy_a), .done(done_a)
  );

  ub_affine_loop_controller #(
    .EXTENT_0(1), .EXTENT_2(1), .EXTENT_1(1), .II(5), .START_DELAY(0)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .stall(stall),
    .op_en(op_en_b), .ctrl_vars(cv_b), .busy(busy_b), .done(done_b)
  );

  int e0[2] = '{2, 1};
  int e1[2] = '{4, 1};
  int e2[2] = '{3, 1};
  int ii[2] = '{2, 5};
  int sd[2] = '{3, 0};

  // phase: 0 idle, 1 active (delay or run), 2 done
  int phase[2];
  int t[2];
  int k[2];
  int passes[2];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 30)
        $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic exp_fire(int i);
    return (phase[i] == 1) && !stall && (t[i] >= sd[i]) && (((t[i] - sd[i]) % ii[i]) == 0);
  endfunction

  function automatic logic [47:0] exp_cv(int i);
    logic [2:0][15:0] v;
    int n, kk;
    n  = e0[i] * e1[i] * e2[i];
    kk = (k[i] < n) ? k[i] : n - 1;
    v[1] = 16'(kk % e1[i]);
    v[2] = 16'((kk / e1[i]) % e2[i]);
    v[0] = 16'(kk / (e1[i] * e2[i]));
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      phase[i] = 0;
      t[i] = 0;
      k[i] = 0;
    end
  endtask

  task automatic model_step();
    logic f;
    for (int i = 0; i < 2; i++) begin
      f = exp_fire(i);
      if (flush) begin
        phase[i] = 0; t[i] = 0; k[i] = 0;
      end else if (phase[i] != 1 && start) begin
        phase[i] = 1; t[i] = 0; k[i] = 0;
      end else if (phase[i] == 1 && !stall) begin
        if (f) begin
          k[i]++;
          if (k[i] == e0[i] * e1[i] * e2[i]) begin
            phase[i] = 2;
            passes[i]++;
          end
        end
        t[i]++;
      end
    end
  endtask

  task automatic check_all();
    chk("op_en_a", 48'(op_en_a), 48'(exp_fire(0)));
    chk("ctrl_vars_a", cv_a, exp_cv(0));
    chk("busy_a", 48'(busy_a), 48'(phase[0] == 1));
    chk("done_a", 48'(done_a), 48'(phase[0] == 2));
    chk("op_en_b", 48'(op_en_b), 48'(exp_fire(1)));
    chk("ctrl_vars_b", cv_b, exp_cv(1));
    chk("busy_b", 48'(busy_b), 48'(phase[1] == 1));
    chk("done_b", 48'(done_b), 48'(phase[1] == 2));
  endtask

  initial begin
    passes[0] = 0;
    passes[1] = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      start = ($urandom_range(5) == 0);
      stall = ($urandom_range(4) == 0);
      flush = ($urandom_range(249) == 0);
      if ($urandom_range(399) == 0) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        #1;
        rst_n = 1'b1;
      end
      #1;
      check_all();
      model_step();
    end

    chk("passes_a_seen", 48'(passes[0] > 0), 48'd1);
    chk("passes_b_seen", 48'(passes[1] > 0), 48'd1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
